// File: rtl/histogram_accum_pkg.sv
// Shared definitions for the per-frame pixel histogram.
//   state_t       controller states (see the table in histogram_accum.sv)
//   DRAIN_CYCLES  cycles spent letting the increment pipeline retire
//   DRAIN_LOAD    start value of the drain down-counter
//   is_busy()     busy flag derived from a state
package histogram_accum_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_ACCUM      = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_RD_ADDR    = 3'd4,
        ST_RD_PRESENT = 3'd5
    } state_t;

    localparam int         DRAIN_CYCLES = 2;
    localparam logic [1:0] DRAIN_LOAD   = 2'(DRAIN_CYCLES - 1);

    function automatic logic is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_ACCUM));
    endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Bin storage: simple dual-port synchronous RAM, 2**ADDR_W x DATA_W.
// One-cycle read latency, read-before-write on an address collision.
// The read data register only updates when i_re is high, so a word that was
// read stays on o_rdata for as long as the reader needs it. No reset.
//   clk      clock, rising edge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable
//   i_raddr  read address
//   o_rdata  read data, valid the cycle after i_re
module hist_bin_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Both accesses sample the array before the edge, so a same-address
    // read returns the old contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/histogram_accum.sv
// Per-frame pixel histogram. Each accepted pixel increments its bin through a
// two-stage read-modify-write pipeline at full pixel rate. At frame end the
// bins are streamed out over a valid/ready port and zeroed as they are read.
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   frame_start  pulse, opens the accumulation window (from IDLE)
//   frame_end    pulse, closes the window and starts readout (from ACCUM)
//   pix_valid    pixel strobe
//   pix_data     pixel value, used directly as bin index
//   rd_valid     readout word valid
//   rd_ready     readout word accepted
//   rd_bin       bin index of the readout word
//   rd_count     count of that bin
//   rd_last      marks the final bin
//   busy         clearing, draining or reading out
//   overflow     sticky, some bin reached or passed all-ones
//   dropped      sticky, a pixel arrived outside the accumulation window
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_CLEAR      | sweep zeros into every bin, one per cycle
// ST_IDLE       | waiting for frame_start
// ST_ACCUM      | pixels increment bins; frame_end closes the window
// ST_DRAIN      | let the last increments retire before reading
// ST_RD_ADDR    | read bin k from RAM
// ST_RD_PRESENT | present bin k until accepted, then zero it
module histogram_accum
    import histogram_accum_pkg::*;
#(
    parameter int PIXEL_W  = 10,
    parameter int COUNT_W  = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               frame_end,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] pix_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [PIXEL_W-1:0] rd_bin,
    output logic [COUNT_W-1:0] rd_count,
    output logic               rd_last,
    output logic               busy,
    output logic               overflow,
    output logic               dropped
);

    localparam logic [PIXEL_W-1:0] LAST_BIN  = '1;
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_W-1:0] CNT_LIMIT = CNT_MAX - 1'b1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PIXEL_W-1:0] r_addr;
    logic [PIXEL_W-1:0] w_addr_nxt;
    logic [1:0]         r_drain_cnt;
    logic [1:0]         w_drain_cnt_nxt;

    logic               r_s1_valid;
    logic [PIXEL_W-1:0] r_s1_bin;
    logic               r_fw_valid;
    logic [PIXEL_W-1:0] r_fw_bin;
    logic [COUNT_W-1:0] r_fw_val;
    logic               r_overflow;
    logic               r_dropped;

    logic               w_pix_accept;
    logic               w_frame_open;
    logic               w_fwd_hit;
    logic [COUNT_W-1:0] w_old;
    logic [COUNT_W-1:0] w_inc;
    logic               w_at_limit;

    logic               w_ram_we;
    logic [PIXEL_W-1:0] w_ram_waddr;
    logic [COUNT_W-1:0] w_ram_wdata;
    logic               w_ram_re;
    logic [PIXEL_W-1:0] w_ram_raddr;
    logic [COUNT_W-1:0] w_ram_rdata;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_CLEAR;
            r_addr      <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // r_addr is shared: clear sweep pointer in ST_CLEAR, readout bin k in the
    // read states. Both start from zero and never overlap.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_addr == LAST_BIN) begin
                    w_state_nxt = ST_IDLE;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (frame_start) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (frame_end) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = ST_RD_ADDR;
                    w_addr_nxt  = '0;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 1'b1;
                end
            end
            ST_RD_ADDR: begin
                w_state_nxt = ST_RD_PRESENT;
            end
            ST_RD_PRESENT: begin
                if (rd_ready) begin
                    if (r_addr == LAST_BIN) begin
                        w_state_nxt = ST_IDLE;
                        w_addr_nxt  = '0;
                    end else begin
                        w_state_nxt = ST_RD_ADDR;
                        w_addr_nxt  = r_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_addr_nxt  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Increment pipeline
    // ------------------------------------------------------------------
    assign w_pix_accept = pix_valid && (r_state == ST_ACCUM);
    assign w_frame_open = frame_start && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_bin   <= '0;
            r_fw_valid <= 1'b0;
            r_fw_bin   <= '0;
            r_fw_val   <= '0;
        end else begin
            r_s1_valid <= w_pix_accept;
            if (w_pix_accept) begin
                r_s1_bin <= pix_data;
            end
            r_fw_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_fw_bin <= r_s1_bin;
                r_fw_val <= w_inc;
            end
        end
    end

    // The RAM read for S2 was issued on the same edge the previous increment
    // was written, so it returns the stale count for back-to-back hits on one
    // bin; take the value we just wrote instead. A gap of two or more cycles
    // is already visible in the RAM.
    assign w_fwd_hit  = r_fw_valid && (r_fw_bin == r_s1_bin);
    assign w_old      = w_fwd_hit ? r_fw_val : w_ram_rdata;
    assign w_at_limit = (w_old >= CNT_LIMIT);

    always_comb begin
        w_inc = w_old + 1'b1;
        if (SATURATE && (w_old == CNT_MAX)) begin
            w_inc = w_old;
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else if (w_frame_open) begin
            r_overflow <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            if (r_s1_valid && w_at_limit) begin
                r_overflow <= 1'b1;
            end
            if (pix_valid && (r_state != ST_ACCUM)) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM ports
    // ------------------------------------------------------------------
    // Write sources are separated by state: the sweep only in ST_CLEAR,
    // increments only in ST_ACCUM/ST_DRAIN, zero-writes only in ST_RD_PRESENT.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_addr;
        w_ram_wdata = '0;
        if (r_state == ST_CLEAR) begin
            w_ram_we = 1'b1;
        end else if (r_s1_valid) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_s1_bin;
            w_ram_wdata = w_inc;
        end else if ((r_state == ST_RD_PRESENT) && rd_ready) begin
            w_ram_we = 1'b1;
        end
    end

    // Reads are enabled only when needed so the readout word stays on the
    // RAM output register while rd_ready is held low.
    assign w_ram_re    = w_pix_accept || (r_state == ST_RD_ADDR);
    assign w_ram_raddr = (r_state == ST_RD_ADDR) ? r_addr : pix_data;

    hist_bin_ram #(
        .ADDR_W (PIXEL_W),
        .DATA_W (COUNT_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Readout fields are gated by rd_valid so they read zero whenever no word
    // is offered, including straight out of reset when the RAM register holds
    // garbage. busy reflects the clear sweep, which starts in reset.
    assign rd_valid = (r_state == ST_RD_PRESENT);
    assign rd_bin   = rd_valid ? r_addr : '0;
    assign rd_count = rd_valid ? w_ram_rdata : '0;
    assign rd_last  = rd_valid && (r_addr == LAST_BIN);
    assign busy     = is_busy(r_state);
    assign overflow = r_overflow;
    assign dropped  = r_dropped;

endmodule

// File: tb/tb_histogram_accum.sv
module tb_histogram_accum;

    localparam int PW  = 10;
    localparam int CW  = 32;
    localparam int NB  = 1 << PW;
    localparam int SPW = 2;
    localparam int SCW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_end = 1'b0;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          rd_ready = 1'b1;

    logic          rd_valid, rd_last, busy, overflow, dropped;
    logic [PW-1:0] rd_bin;
    logic [CW-1:0] rd_count;

    logic           s_ready;
    logic           sa_rd_valid, sa_rd_last, sa_busy, sa_overflow, sa_dropped;
    logic [SPW-1:0] sa_rd_bin;
    logic [SCW-1:0] sa_rd_count;
    logic           sw_rd_valid, sw_rd_last, sw_busy, sw_overflow, sw_dropped;
    logic [SPW-1:0] sw_rd_bin;
    logic [SCW-1:0] sw_rd_count;

    assign s_ready = 1'b1;

    always #5 clk = ~clk;

    histogram_accum #(.PIXEL_W(PW), .COUNT_W(CW), .SATURATE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_data(pix_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last), .busy(busy),
        .overflow(overflow), .dropped(dropped)
    );

    histogram_accum #(.PIXEL_W(SPW), .COUNT_W(SCW), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_data(pix_data[SPW-1:0]), .rd_valid(sa_rd_valid), .rd_ready(s_ready),
        .rd_bin(sa_rd_bin), .rd_count(sa_rd_count), .rd_last(sa_rd_last), .busy(sa_busy),
        .overflow(sa_overflow), .dropped(sa_dropped)
    );

    histogram_accum #(.PIXEL_W(SPW), .COUNT_W(SCW), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_data(pix_data[SPW-1:0]), .rd_valid(sw_rd_valid), .rd_ready(s_ready),
        .rd_bin(sw_rd_bin), .rd_count(sw_rd_count), .rd_last(sw_rd_last), .busy(sw_busy),
        .overflow(sw_overflow), .dropped(sw_dropped)
    );

    // Model state, owned by the stimulus process: per-frame bin counts.
    int unsigned m_bins [NB];
    int          frame_id = 0;

    // Check requests from the stimulus process, executed by the compare process.
    bit     req_tog = 1'b0;
    string  req_name = "";
    longint req_act = 0;
    longint req_exp = 0;

    // Owned by the compare process.
    int          total = 0;
    int          bad = 0;
    int          words = 0;
    int          m_next_bin = 0;
    bit          req_seen = 1'b0;
    bit          prev_hold = 1'b0;
    logic [PW-1:0] prev_bin = '0;
    logic [CW-1:0] prev_cnt = '0;
    bit          seen_sat = 1'b0;
    bit          seen_wrap = 1'b0;

    always @(negedge clk) begin
        longint lit;
        longint exp_cnt;
        bit     exp_last;
        if (req_tog != req_seen) begin
            req_seen = req_tog;
            total++;
            if (req_act != req_exp) begin
                bad++;
                $display("FAIL %s: got %0d, expected %0d", req_name, req_act, req_exp);
            end
        end
        if (!reset_n) begin
            m_next_bin = 0;
            prev_hold  = 1'b0;
        end else begin
            if (prev_hold) begin
                total++;
                if (!rd_valid || rd_bin != prev_bin || rd_count != prev_cnt) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%0d bin=%0d count=%0d, expected valid=1 bin=%0d count=%0d",
                             rd_valid, rd_bin, rd_count, prev_bin, prev_cnt);
                end
            end
            if (rd_valid && rd_ready) begin
                exp_cnt  = longint'(m_bins[m_next_bin]);
                exp_last = (m_next_bin == NB - 1);
                total++;
                if (rd_bin != PW'(m_next_bin) || longint'(rd_count) != exp_cnt || rd_last != exp_last) begin
                    bad++;
                    $display("FAIL readout frame=%0d: got bin=%0d count=%0d last=%0d, expected bin=%0d count=%0d last=%0d",
                             frame_id, rd_bin, rd_count, rd_last, m_next_bin, exp_cnt, exp_last);
                end
                lit = -1;
                case (frame_id)
                    2: if (m_next_bin == 5) lit = 4; else if (m_next_bin == 7) lit = 1; else if (m_next_bin == 6) lit = 0;
                    3: if (m_next_bin == 3 || m_next_bin == 9) lit = 50;
                    4: if (m_next_bin == 12) lit = 3;
                    6: if (m_next_bin == 0 || m_next_bin == 41) lit = 0;
                    7: if (m_next_bin == 100) lit = 3;
                    default: lit = -1;
                endcase
                if (lit >= 0) begin
                    total++;
                    if (longint'(rd_count) != lit) begin
                        bad++;
                        $display("FAIL literal frame=%0d bin=%0d: got %0d, expected %0d",
                                 frame_id, m_next_bin, rd_count, lit);
                    end
                end
                m_next_bin = (m_next_bin + 1) % NB;
                words++;
            end
            prev_hold = rd_valid && !rd_ready;
            prev_bin  = rd_bin;
            prev_cnt  = rd_count;
            if (frame_id == 5 && sa_rd_valid && sa_rd_bin == '0) begin
                seen_sat = 1'b1;
                total++;
                if (sa_rd_count != 4'd15) begin
                    bad++;
                    $display("FAIL sat_bin0: got %0d, expected 15", sa_rd_count);
                end
            end
            if (frame_id == 5 && sw_rd_valid && sw_rd_bin == '0) begin
                seen_wrap = 1'b1;
                total++;
                if (sw_rd_count != 4'd4) begin
                    bad++;
                    $display("FAIL wrap_bin0: got %0d, expected 4", sw_rd_count);
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        req_name = name;
        req_act  = act;
        req_exp  = exp;
        req_tog  = ~req_tog;
        @(posedge clk); #1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic frame_begin(input int id, output int words0);
        int n = 0;
        while (busy && n < 6000) begin
            cyc();
            n++;
        end
        if (busy) chk("idle_wait", busy, 0);
        frame_id = id;
        foreach (m_bins[i]) m_bins[i] = 0;
        words0 = words;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic pix(input int p);
        pix_valid = 1'b1;
        pix_data  = PW'(p);
        m_bins[p]++;
        cyc();
        pix_valid = 1'b0;
    endtask

    task automatic pix_end(input int p);
        pix_valid = 1'b1;
        pix_data  = PW'(p);
        frame_end = 1'b1;
        m_bins[p]++;
        cyc();
        pix_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic frame_close();
        frame_end = 1'b1;
        cyc();
        frame_end = 1'b0;
    endtask

    task automatic wait_readout();
        int n = 0;
        while (busy && n < 6000) begin
            cyc();
            n++;
        end
        if (busy) chk("readout_end", busy, 0);
    endtask

    task automatic wait_word(input int b);
        int n = 0;
        while (!(rd_valid && rd_bin == PW'(b)) && n < 6000) begin
            cyc();
            n++;
        end
    endtask

    task automatic count_clear(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            n++;
            cyc();
        end
        chk(name, n, NB);
    endtask

    initial begin
        int w0;
        logic sa_ovf, sw_ovf;
        #2;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dropped", dropped, 0);
        reset_n = 1'b1;
        count_clear("clear_cycles");

        frame_begin(1, w0);
        frame_close();
        wait_readout();
        chk("words_empty", words - w0, NB);

        frame_begin(2, w0);
        pix(5); pix(5); pix(5); pix(5); pix(7);
        frame_close();
        wait_readout();
        chk("words_f2", words - w0, NB);
        chk("dropped_f2", dropped, 0);

        frame_begin(3, w0);
        for (int i = 0; i < 100; i++) begin
            if (i == 99) pix_end(9);
            else         pix((i % 2 == 0) ? 3 : 9);
        end
        wait_readout();
        chk("words_f3", words - w0, NB);

        frame_begin(4, w0);
        pix(12); pix(11); cyc(); pix(12); pix(13); cyc(); cyc(); pix(12);
        frame_close();
        wait_word(12);
        rd_ready = 1'b0;
        repeat (20) cyc();
        chk("stall_word", {rd_valid, rd_bin}, {1'b1, 10'd12});
        rd_ready = 1'b1;
        wait_readout();
        chk("words_f4", words - w0, NB);

        frame_begin(5, w0);
        for (int i = 0; i < 20; i++) pix(0);
        frame_close();
        wait_readout();
        sa_ovf = sa_overflow;
        sw_ovf = sw_overflow;

        frame_begin(6, w0);
        chk("sat_overflow", sa_ovf, 1);
        chk("wrap_overflow", sw_ovf, 1);
        chk("seen_sat", seen_sat, 1);
        chk("seen_wrap", seen_wrap, 1);
        chk("main_overflow", overflow, 0);
        pix(1); pix(2);
        frame_close();
        wait_word(40);
        pix_valid = 1'b1;
        pix_data  = PW'(41);
        cyc();
        pix_valid = 1'b0;
        wait_readout();
        chk("words_f6", words - w0, NB);
        chk("dropped_f6", dropped, 1);

        frame_begin(7, w0);
        pix(100); pix(100); pix(100);
        frame_close();
        wait_word(300);
        chk("pre_reset_word", {rd_valid, rd_bin}, {1'b1, 10'd300});
        reset_n = 1'b0;
        #1;
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_dropped", dropped, 0);
        foreach (m_bins[i]) m_bins[i] = 0;
        reset_n = 1'b1;
        count_clear("clear_cycles_2");

        frame_begin(8, w0);
        frame_close();
        wait_readout();
        chk("words_f8", words - w0, NB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
